// File: rtl/mem_access_stage.sv
// MEM stage of the pipeline: issues loads/stores over a req/ready handshake,
// aligns load data, builds store strobes, and stalls upstream while memory is slow.
module mem_access_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] MEM_alu_result,
    input  logic [XLEN-1:0] MEM_store_data,
    input  logic [4:0]      MEM_rd,
    input  logic            MEM_we,
    input  logic            MEM_mem_read,
    input  logic            MEM_mem_write,
    input  logic [2:0]      MEM_funct3,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] Mem_data_mem,
    output logic [4:0]      MEM_wb_rd,
    output logic            MEM_wb_we,
    output logic            mem_stall,
    output logic            mem_fault
);

    // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       op, is_load, is_store, illegal, misaligned, bad;
    logic [1:0] lane;

    // Pick the addressed byte/half out of the returned word and extend it.
    function automatic logic [31:0] load_format(input logic [31:0] w,
                                                input logic [1:0]  ln,
                                                input logic [2:0]  f3);
        logic        [15:0] h;
        logic        [7:0]  b;
        logic signed [31:0] r;
        h = ln[1] ? w[31:16] : w[15:0];
        b = ln[0] ? h[15:8]  : h[7:0];
        case (f3)
            3'b000:  r = 32'(signed'(b));
            3'b001:  r = 32'(signed'(h));
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replicate store data into every lane it may land in.
    function automatic logic [31:0] store_data(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Byte strobes for a store of the given size at the given lane.
    function automatic logic [3:0] store_strb(input logic [1:0] ln, input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001 << ln;
            2'b01:   return 4'b0011 << {ln[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Decode the access and flag illegal or misaligned memory ops.
    always_comb begin
        op       = MEM_mem_read | MEM_mem_write;
        is_store = MEM_mem_write;
        is_load  = MEM_mem_read & ~MEM_mem_write;
        lane     = MEM_alu_result[1:0];
        if (is_store)
            illegal = MEM_funct3[2] | (MEM_funct3[1:0] == 2'b11);
        else
            illegal = (MEM_funct3 == 3'b011) | (MEM_funct3[2:1] == 2'b11);
        case (MEM_funct3[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
        bad = op & (illegal | misaligned);
    end

    // Handshake FSM next-state, stall/fault generation and writeback gating.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        mem_fault = 1'b0;
        case (state_q)
            IDLE: begin
                if (bad) begin
                    mem_fault = 1'b1;
                end else if (op) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        mem_stall = 1'b1;
                        state_d   = WAIT;
                        cnt_d     = '0;
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // Memory never answered: drop the instruction and report it.
                    mem_fault = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
            mem_fault = 1'b0;
        end
        MEM_wb_we = MEM_we & ~rst & ~mem_stall & ~mem_fault;
    end

    // Memory-facing datapath and writeback data selection.
    always_comb begin
        dmem_we      = MEM_mem_write;
        dmem_addr    = {MEM_alu_result[XLEN-1:2], 2'b00};
        dmem_wdata   = store_data(MEM_store_data, MEM_funct3[1:0]);
        dmem_wstrb   = is_store ? store_strb(lane, MEM_funct3[1:0]) : 4'b0000;
        MEM_wb_rd    = MEM_rd;
        Mem_data_mem = is_load ? load_format(dmem_rdata, lane, MEM_funct3) : MEM_alu_result;
    end

    // FSM state and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
